// File: rtl/mps_intl_manager.sv
// Purpose : MPS interlock aggregator: sync, debounce, mask, sticky latch, first-fault capture, arm/trip/clear FSM.
// Latency : raw high to o_intl_flag high is L+3 cycles (2 sync + L debounce + 1 latch); o_clr_ack/o_clr_nak one cycle after i_clr.
// Backpr. : none; every input is a level or a single-cycle pulse. Optional watchdog channel: `define MPS_INTL_WDT_EN.
module mps_intl_manager #(
    parameter int NUM_CH  = 24,
    parameter int FILT_W  = 8,
    parameter int TS_W    = 32,
    parameter int IDX_W   = $clog2(NUM_CH + 1)
`ifdef MPS_INTL_WDT_EN
    ,
    parameter int WDT_LIM = 200000
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_intl_raw,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [FILT_W-1:0] i_filt_len,
    input  logic              i_arm,
    input  logic              i_clr,
`ifdef MPS_INTL_WDT_EN
    input  logic              i_wdt_kick,
    output logic [NUM_CH:0]   o_intl_latch,
`else
    output logic [NUM_CH-1:0] o_intl_latch,
`endif
    output logic              o_intl_flag,
    output logic [IDX_W-1:0]  o_first_idx,
    output logic              o_first_valid,
    output logic [TS_W-1:0]   o_first_ts,
    output logic [1:0]        o_state,
    output logic              o_pwm_permit,
    output logic              o_clr_ack,
    output logic              o_clr_nak
);

`ifdef MPS_INTL_WDT_EN
    localparam int LAT_W = NUM_CH + 1;
`else
    localparam int LAT_W = NUM_CH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TRIPPED = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   sync_s1;
    logic [NUM_CH-1:0]   sync_s2;
    logic [FILT_W-1:0]   filt_cnt [NUM_CH];
    logic [NUM_CH-1:0]   filt;
    logic [LAT_W-1:0]    fault;
    logic [LAT_W-1:0]    latch_q;
    logic [LAT_W-1:0]    latch_nxt;
    logic [IDX_W-1:0]    first_idx_nxt;
    logic [TS_W-1:0]     ts_q;
    logic                intl_flag;
    logic                clr_ok;
    logic                first_edge;

    // Two-flop synchroniser for the asynchronous interlock sources.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= i_intl_raw;
            sync_s2 <= sync_s1;
        end
    end

    // Debounce counters: clear on a low level, count up to L and hold there.
    // A changed L is used immediately without restarting the count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int c = 0; c < NUM_CH; c++) filt_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!sync_s2[c]) begin
                    filt_cnt[c] <= '0;
                end else if (filt_cnt[c] < i_filt_len) begin
                    filt_cnt[c] <= filt_cnt[c] + FILT_W'(1);
                end
            end
        end
    end

    // Filtered level: high once the synchronised input has been high for L+1 cycles.
    always_comb begin
        filt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            filt[c] = sync_s2[c] && (filt_cnt[c] >= i_filt_len);
        end
    end

`ifdef MPS_INTL_WDT_EN
    localparam int              WDT_W   = $clog2(WDT_LIM + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIM);

    logic [WDT_W-1:0] wdt_cnt;
    logic             kick_q;
    logic             wdt_fault;

    // Watchdog: counts ARMED cycles since the last kick edge, saturating at the limit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wdt_cnt <= '0;
            kick_q  <= 1'b0;
        end else begin
            kick_q <= i_wdt_kick;
            if ((state_q != ST_ARMED) || (i_wdt_kick ^ kick_q)) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt != WDT_MAX) begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
        end
    end

    // The watchdog bit bypasses both the mask and the debounce filter.
    assign wdt_fault = (state_q == ST_ARMED) && (wdt_cnt == WDT_MAX);
    assign fault     = {wdt_fault, filt & i_mask};
`else
    assign fault     = filt & i_mask;
`endif

    assign intl_flag = |latch_q;
    // A clear loses against any fault present in the same cycle.
    assign clr_ok    = i_clr && (fault == '0);

    // Next latch vector: clear wins when accepted, otherwise accumulate outside IDLE.
    always_comb begin
        latch_nxt = latch_q;
        if (clr_ok) begin
            latch_nxt = '0;
        end else if (state_q != ST_IDLE) begin
            latch_nxt = latch_q | fault;
        end
    end

    assign first_edge = (latch_q == '0) && (latch_nxt != '0);

    // Lowest set bit of the incoming latch vector; several simultaneous faults report the smallest index.
    always_comb begin
        first_idx_nxt = '0;
        for (int i = LAT_W - 1; i >= 0; i--) begin
            if (latch_nxt[i]) first_idx_nxt = IDX_W'(i);
        end
    end

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Sticky latches, first-fault record and clear handshake pulses.
    // The captured timestamp is the one shown while o_intl_flag first reads high.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            latch_q       <= '0;
            o_first_idx   <= '0;
            o_first_ts    <= '0;
            o_first_valid <= 1'b0;
            o_clr_ack     <= 1'b0;
            o_clr_nak     <= 1'b0;
        end else begin
            latch_q   <= latch_nxt;
            o_clr_ack <= clr_ok;
            o_clr_nak <= i_clr && !clr_ok;
            if (clr_ok) begin
                o_first_idx   <= '0;
                o_first_ts    <= '0;
                o_first_valid <= 1'b0;
            end else if (first_edge) begin
                o_first_idx   <= first_idx_nxt;
                o_first_ts    <= ts_q + TS_W'(1);
                o_first_valid <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next state: an accepted clear decides the state from i_arm; a trip outranks disarm.
    always_comb begin
        state_nxt = state_q;
        if (clr_ok) begin
            state_nxt = i_arm ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (i_arm && !intl_flag) state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (intl_flag)   state_nxt = ST_TRIPPED;
                    else if (!i_arm) state_nxt = ST_IDLE;
                end
                ST_TRIPPED: state_nxt = ST_TRIPPED;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_intl_latch = latch_q;
    assign o_intl_flag  = intl_flag;
    assign o_state      = state_q;
    // PWM falls in the same cycle a latch sets, before the FSM reaches TRIPPED.
    assign o_pwm_permit = (state_q == ST_ARMED) && !intl_flag;

endmodule

// File: tb/tb_mps_intl_manager.sv
// Purpose : randomized and directed bench for mps_intl_manager against a cycle-level behavioural model.
// Latency : model advances once per i_clk edge; outputs sampled 1 time unit after the edge.
// Backpr. : none.
module tb_mps_intl_manager;
    localparam int NUM_CH = 24;
    localparam int FILT_W = 8;
    localparam int TS_W   = 32;
    localparam int IDX_W  = $clog2(NUM_CH + 1);
    localparam int HIST   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] mask;
    logic [FILT_W-1:0] filt_len;
    logic              arm;
    logic              clr;
    logic              flag;
    logic [NUM_CH-1:0] latch;
    logic [IDX_W-1:0]  first_idx;
    logic              first_valid;
    logic [TS_W-1:0]   first_ts;
    logic [1:0]        state;
    logic              pwm;
    logic              ack;
    logic              nak;

    int n_chk = 0;
    int n_err = 0;

    // Model state: raw history (index 0 = sample taken at the latest edge) and architectural outputs.
    logic [NUM_CH-1:0] hist [HIST];
    logic [NUM_CH-1:0] m_latch;
    int                m_state;
    logic              m_fv;
    int                m_fidx;
    logic [TS_W-1:0]   m_fts;
    logic [TS_W-1:0]   m_ts;
    logic              m_ack;
    logic              m_nak;

    mps_intl_manager #(
        .NUM_CH (NUM_CH),
        .FILT_W (FILT_W),
        .TS_W   (TS_W),
        .IDX_W  (IDX_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_intl_raw    (raw),
        .i_mask        (mask),
        .i_filt_len    (filt_len),
        .i_arm         (arm),
        .i_clr         (clr),
        .o_intl_latch  (latch),
        .o_intl_flag   (flag),
        .o_first_idx   (first_idx),
        .o_first_valid (first_valid),
        .o_first_ts    (first_ts),
        .o_state       (state),
        .o_pwm_permit  (pwm),
        .o_clr_ack     (ack),
        .o_clr_nak     (nak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < HIST; j++) hist[j] = '0;
        m_latch = '0;
        m_state = 0;
        m_fv    = 1'b0;
        m_fidx  = 0;
        m_fts   = '0;
        m_ts    = '0;
        m_ack   = 1'b0;
        m_nak   = 1'b0;
    endtask

    // One clock edge of the specified behaviour, evaluated from the pre-edge inputs.
    // A channel passes the filter when its raw sample was high at the L+1 edges before the previous one.
    task automatic model_edge();
        logic [NUM_CH-1:0] filt;
        logic [NUM_CH-1:0] fault;
        logic [NUM_CH-1:0] nl;
        int                ns;
        filt = '1;
        for (int j = 1; j <= int'(filt_len) + 1; j++) filt &= hist[j];
        fault = filt & mask;
        ns    = m_state;
        m_ack = 1'b0;
        m_nak = 1'b0;
        if (clr && fault == '0) begin
            m_ack   = 1'b1;
            m_latch = '0;
            m_fv    = 1'b0;
            m_fidx  = 0;
            m_fts   = '0;
            ns      = arm ? 1 : 0;
        end else begin
            m_nak = clr;
            nl    = (m_state != 0) ? (m_latch | fault) : m_latch;
            if (m_latch == '0 && nl != '0) begin
                m_fv  = 1'b1;
                m_fts = m_ts + 1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (nl[i]) m_fidx = i;
            end
            case (m_state)
                0: if (arm && m_latch == '0) ns = 1;
                1: begin
                    if (m_latch != '0) ns = 2;
                    else if (!arm)     ns = 0;
                end
                default: ;
            endcase
            m_latch = nl;
        end
        m_state = ns;
        for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = raw;
        m_ts    = m_ts + 1;
    endtask

    task automatic compare_all();
        chk("flag",   64'(flag),        64'(|m_latch));
        chk("latch",  64'(latch),       64'(m_latch));
        chk("state",  64'(state),       64'(m_state));
        chk("pwm",    64'(pwm),         64'(m_state == 1 && m_latch == '0));
        chk("fvalid", 64'(first_valid), 64'(m_fv));
        chk("fidx",   64'(first_idx),   64'(m_fidx));
        chk("fts",    64'(first_ts),    64'(m_fts));
        chk("ack",    64'(ack),         64'(m_ack));
        chk("nak",    64'(nak),         64'(m_nak));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset asserted mid-cycle, checked before any edge, released away from the edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 compare_all();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_flag",  64'(flag),  64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic do_clear();
        raw = '0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        raw = '0; mask = '1; filt_len = '0; arm = 1'b0; clr = 1'b0;
        do_reset();

        // L=0: single channel trip, L+3 latency, PWM drop and trip transition.
        arm = 1'b1;
        repeat (2) tick();
        chk("t1_armed", 64'(state), 64'd1);
        raw[5] = 1'b1;
        repeat (2) tick();
        chk("t1_flag_t2", 64'(flag), 64'd0);
        tick();
        chk("t1_flag_t3", 64'(flag), 64'd1);
        chk("t1_idx",     64'(first_idx), 64'd5);
        chk("t1_pwm",     64'(pwm), 64'd0);
        chk("t1_st_t3",   64'(state), 64'd1);
        tick();
        chk("t1_tripped", 64'(state), 64'd2);
        do_clear();
        chk("t1_ack",   64'(ack), 64'd1);
        chk("t1_rearm", 64'(state), 64'd1);

        // L=4: a 4-cycle pulse is rejected, a 5-cycle pulse latches after 7 cycles.
        filt_len = FILT_W'(4);
        raw[2] = 1'b1;
        repeat (4) tick();
        raw = '0;
        repeat (10) tick();
        chk("t2_short", 64'(flag), 64'd0);
        raw[2] = 1'b1;
        repeat (5) tick();
        raw = '0;
        tick();
        chk("t2_t6", 64'(flag), 64'd0);
        tick();
        chk("t2_t7", 64'(flag), 64'd1);
        do_clear();
        filt_len = '0;

        // Simultaneous faults: both latch, lowest index reported, later fault does not overwrite.
        raw[3] = 1'b1;
        raw[9] = 1'b1;
        repeat (3) tick();
        chk("t3_l3",  64'(latch[3]), 64'd1);
        chk("t3_l9",  64'(latch[9]), 64'd1);
        chk("t3_idx", 64'(first_idx), 64'd3);
        raw[1] = 1'b1;
        repeat (3) tick();
        chk("t3_l1",   64'(latch[1]), 64'd1);
        chk("t3_keep", 64'(first_idx), 64'd3);
        do_clear();

        // Masked channel, unmask trips, clear rejected while active, accepted once low.
        mask[7] = 1'b0;
        raw[7]  = 1'b1;
        repeat (5) tick();
        chk("t4_masked", 64'(flag), 64'd0);
        mask = '1;
        tick();
        chk("t4_unmask", 64'(flag), 64'd1);
        tick();
        chk("t4_trip", 64'(state), 64'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_nak",  64'(nak), 64'd1);
        chk("t4_kept", 64'(latch[7]), 64'd1);
        do_clear();
        chk("t4_ack",   64'(ack), 64'd1);
        chk("t4_armed", 64'(state), 64'd1);
        chk("t4_flag",  64'(flag), 64'd0);

        // Reset in TRIPPED, then the timestamp restarts from release.
        raw[0] = 1'b1;
        repeat (4) tick();
        chk("t5_trip", 64'(state), 64'd2);
        raw = '0;
        do_reset();
        while (m_ts < 100) tick();
        raw[4] = 1'b1;
        repeat (3) tick();
        chk("t5_ts",  64'(first_ts), 64'd103);
        chk("t5_idx", 64'(first_idx), 64'd4);
        do_clear();

        // Randomized segments; L only changes after all inputs have been low long enough to drain the filter.
        for (int seg = 0; seg < 12; seg++) begin
            raw = '0;
            clr = 1'b0;
            repeat (4) tick();
            filt_len = FILT_W'($urandom_range(0, 5));
            for (int k = 0; k < 250; k++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (raw[c]) begin
                        if ($urandom_range(0, 5) == 0) raw[c] = 1'b0;
                    end else if ($urandom_range(0, 79) == 0) begin
                        raw[c] = 1'b1;
                    end
                end
                if ($urandom_range(0, 40) == 0) mask = NUM_CH'($urandom | $urandom | $urandom);
                if ($urandom_range(0, 60) == 0) arm = ~arm;
                clr = ($urandom_range(0, 12) == 0);
                tick();
            end
            if (seg == 6) begin
                raw = '0;
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
